// File: rtl/mips_boot_ctrl_if.sv
// Host/core-facing signal bundle of the boot sequencer.
// master = sequencer side, slave = host/core/testbench side.
interface mips_boot_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              prog_valid;
   logic [31:0]       prog_data;
   logic              prog_last;
   logic              prog_ready;
   logic              reg_we;
   logic [4:0]        reg_addr;
   logic [31:0]       reg_wdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_pc_clr;
   logic              core_run;
   logic              core_halted;
   logic              busy;
   logic              done;
   logic              timeout;
   logic              overflow;
   logic [CNT_W-1:0]  run_cycles;

   modport master (
      input  start, prog_valid, prog_data, prog_last, core_halted,
      output prog_ready, reg_we, reg_addr, reg_wdata, mem_we, mem_addr, mem_wdata,
             core_pc_clr, core_run, busy, done, timeout, overflow, run_cycles
   );

   modport slave (
      output start, prog_valid, prog_data, prog_last, core_halted,
      input  prog_ready, reg_we, reg_addr, reg_wdata, mem_we, mem_addr, mem_wdata,
             core_pc_clr, core_run, busy, done, timeout, overflow, run_cycles
   );
endinterface

// File: rtl/mips_boot_ctrl.sv
// Boot sequencer for the mips32 core: clears registers, loads the program image,
// clears PC/HALTED, runs the core and measures run length against a watchdog.
module mips_boot_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 1024,
   parameter int NREG    = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input logic              clk1,
   input logic              rst_n,
   mips_boot_ctrl_if.master bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_PCLR = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]        state_q,     state_d;
   logic [4:0]        rcnt_q,      rcnt_d;
   logic [ADDR_W-1:0] wp_q,        wp_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              timeout_q,   timeout_d;
   logic              overflow_q,  overflow_d;
   logic [CNT_W-1:0]  cyc_q,       cyc_d;

   always_comb begin
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      wp_d        = wp_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      timeout_d   = timeout_q;
      overflow_d  = overflow_q;
      cyc_d       = cyc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_CLR;
               rcnt_d     = '0;
               timeout_d  = 1'b0;
               overflow_d = 1'b0;
               cyc_d      = '0;
            end
         end
         S_CLR: begin
            rcnt_d = rcnt_q + 5'd1;
            if (rcnt_q == 5'(NREG - 1)) begin
               state_d = S_LOAD;
               wp_d    = '0;
            end
         end
         S_LOAD: begin
            if (bus.prog_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = wp_q;
               mem_wdata_d = bus.prog_data;
               wp_d        = wp_q + ADDR_W'(1);
               if (bus.prog_last) begin
                  state_d = S_PCLR;
               end else if (wp_q == ADDR_W'(DEPTH - 1)) begin
                  overflow_d = 1'b1;
                  state_d    = S_DONE;
               end
            end
         end
         S_PCLR: state_d = S_RUN;
         S_RUN: begin
            if (cyc_q != '1) begin
               cyc_d = cyc_q + CNT_W'(1);
            end
            // The halting cycle is counted; halt takes priority over the watchdog.
            if (bus.core_halted) begin
               state_d = S_DONE;
            end else if (cyc_d == CNT_W'(TIMEOUT)) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rcnt_q      <= '0;
         wp_q        <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         timeout_q   <= 1'b0;
         overflow_q  <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         wp_q        <= wp_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         timeout_q   <= timeout_d;
         overflow_q  <= overflow_d;
         cyc_q       <= cyc_d;
      end
   end

   assign bus.prog_ready  = (state_q == S_LOAD);
   assign bus.reg_we      = (state_q == S_CLR);
   assign bus.reg_addr    = rcnt_q;
   assign bus.reg_wdata   = '0;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.core_pc_clr = (state_q == S_PCLR);
   assign bus.core_run    = (state_q == S_RUN);
   assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.timeout     = timeout_q;
   assign bus.overflow    = overflow_q;
   assign bus.run_cycles  = cyc_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl: scoreboarded register/memory writes,
// halt, watchdog, overflow, async reset and ignored-start scenarios.
module tb_mips_boot_ctrl;
   localparam int TO = 1000;

   logic clk1 = 1'b0;
   logic rst_n;
   always #5 clk1 = ~clk1;

   mips_boot_ctrl_if #(.ADDR_W(10), .CNT_W(16)) busA ();
   mips_boot_ctrl_if #(.ADDR_W(10), .CNT_W(16)) busB ();

   mips_boot_ctrl #(.ADDR_W(10), .DEPTH(1024), .NREG(32), .CNT_W(16), .TIMEOUT(TO)) u_dut (
      .clk1(clk1), .rst_n(rst_n), .bus(busA));
   mips_boot_ctrl #(.ADDR_W(10), .DEPTH(8), .NREG(32), .CNT_W(16), .TIMEOUT(TO)) u_dut8 (
      .clk1(clk1), .rst_n(rst_n), .bus(busB));

   int checks = 0;
   int failures = 0;
   logic [4:0]  q_reg[$];
   logic [41:0] q_memA[$];
   logic [41:0] q_memB[$];
   int n_pcA = 0, n_loadA = 0, n_runB = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ctl(input bit sel);
      if (sel)
         return {24'b0, busB.prog_ready, busB.reg_we, busB.reg_addr, busB.mem_we, busB.mem_addr,
                 busB.core_pc_clr, busB.core_run, busB.busy, busB.done, busB.timeout,
                 busB.overflow, busB.run_cycles};
      return {24'b0, busA.prog_ready, busA.reg_we, busA.reg_addr, busA.mem_we, busA.mem_addr,
              busA.core_pc_clr, busA.core_run, busA.busy, busA.done, busA.timeout,
              busA.overflow, busA.run_cycles};
   endfunction

   task automatic mon();
      if (busA.reg_we) begin
         chk("reg_queued", 64'(q_reg.size() > 0), 64'd1);
         if (q_reg.size() > 0) chk("reg_addr", 64'(busA.reg_addr), 64'(q_reg.pop_front()));
         chk("reg_wdata", 64'(busA.reg_wdata), 64'd0);
         chk("we_excl", 64'(busA.mem_we), 64'd0);
      end
      if (busA.mem_we) begin
         chk("memA_queued", 64'(q_memA.size() > 0), 64'd1);
         if (q_memA.size() > 0) chk("memA_wr", 64'({busA.mem_addr, busA.mem_wdata}), 64'(q_memA.pop_front()));
      end
      if (busA.core_run)
         chk("run_excl", 64'({busA.prog_ready, busA.core_pc_clr, busA.reg_we, busA.mem_we}), 64'd0);
      if (busB.mem_we) begin
         chk("memB_queued", 64'(q_memB.size() > 0), 64'd1);
         if (q_memB.size() > 0) chk("memB_wr", 64'({busB.mem_addr, busB.mem_wdata}), 64'(q_memB.pop_front()));
      end
      if (busA.core_pc_clr) n_pcA++;
      if (busA.prog_ready)  n_loadA++;
      if (busB.core_run)    n_runB++;
   endtask

   task automatic cyc();
      @(negedge clk1);
      mon();
   endtask

   task automatic pulse_start(input bit sel, input bit push);
      if (sel) busB.start = 1'b1; else busA.start = 1'b1;
      if (push) for (int i = 0; i < 32; i++) q_reg.push_back(5'(i));
      cyc();
      busA.start = 1'b0;
      busB.start = 1'b0;
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [31:0] d, input logic l);
      if (sel) begin
         busB.prog_valid = v; busB.prog_data = d; busB.prog_last = l;
      end else begin
         busA.prog_valid = v; busA.prog_data = d; busA.prog_last = l;
      end
   endtask

   // Drives n words; expectation is queued at the cycle the word is offered while ready.
   task automatic stream(input bit sel, input int n, input bit toggle, input int start_at,
                         input logic [31:0] base, output int acc);
      logic [31:0] d;
      bit got;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         d = (i == n - 1) ? 32'hFFFF_FFFF : base + 32'(i) * 32'h0101_0101;
         set_in(sel, 1'b1, d, i == n - 1);
         if (i == start_at) busA.start = 1'b1;
         got = 1'b0;
         for (int w = 0; w < 60 && !got; w++) begin
            if (sel ? busB.prog_ready : busA.prog_ready) begin
               if (sel) q_memB.push_back({10'(acc), d}); else q_memA.push_back({10'(acc), d});
               acc++;
               got = 1'b1;
            end
            cyc();
            busA.start = 1'b0;
         end
         if (!got) return;
         if (toggle && i < n - 1) begin
            set_in(sel, 1'b0, 32'h0, 1'b0);
            cyc();
         end
      end
      set_in(sel, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic wait_done(input int halt_at, input int maxc, output int runc);
      bit seen = 1'b0;
      runc = 0;
      for (int c = 0; c < maxc && !seen; c++) begin
         cyc();
         if (busA.done) seen = 1'b1;
         else begin
            if (busA.core_run) runc++;
            busA.core_halted = busA.core_run && (runc == halt_at);
         end
      end
      busA.core_halted = 1'b0;
      chk("done_reached", 64'(busA.done), 64'd1);
   endtask

   initial begin
      int acc, rc, pc0, ld0;
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      busA.start = 1'b0; busB.start = 1'b0;
      busA.core_halted = 1'b0; busB.core_halted = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctlA", ctl(1'b0), 64'd0);
      chk("rst_dataA", {busA.reg_wdata, busA.mem_wdata}, 64'd0);
      chk("rst_ctlB", ctl(1'b1), 64'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // 1: nine words, valid held high, halt at run cycle 12
      pc0 = n_pcA; ld0 = n_loadA;
      pulse_start(1'b0, 1'b1);
      chk("start_lat", 64'({busA.reg_we, busA.busy}), 64'b11);
      stream(1'b0, 9, 1'b0, -1, 32'h1000_0000, acc);
      chk("s1_acc", 64'(acc), 64'd9);
      wait_done(12, 200, rc);
      chk("s1_res", 64'({busA.done, busA.timeout, busA.overflow, busA.run_cycles}), 64'({3'b100, 16'd12}));
      chk("s1_runc", 64'(rc), 64'd12);
      chk("s1_pcclr", 64'(n_pcA - pc0), 64'd1);
      chk("s1_load", 64'(n_loadA - ld0), 64'd9);
      chk("s1_regs_left", 64'(q_reg.size()), 64'd0);
      chk("s1_mem_left", 64'(q_memA.size()), 64'd0);

      // 2: valid toggling every other cycle
      pc0 = n_pcA; ld0 = n_loadA;
      pulse_start(1'b0, 1'b1);
      chk("restart_clr", 64'({busA.done, busA.timeout, busA.run_cycles}), 64'd0);
      stream(1'b0, 9, 1'b1, -1, 32'h1000_0000, acc);
      wait_done(12, 200, rc);
      chk("s2_res", 64'({busA.done, busA.timeout, busA.run_cycles}), 64'({2'b10, 16'd12}));
      chk("s2_load", 64'(n_loadA - ld0), 64'd17);
      chk("s2_pcclr", 64'(n_pcA - pc0), 64'd1);
      chk("s2_mem_left", 64'(q_memA.size()), 64'd0);

      // 3: no halt, watchdog fires
      pulse_start(1'b0, 1'b1);
      stream(1'b0, 5, 1'b0, -1, 32'hA5A5_0000, acc);
      wait_done(0, 1100, rc);
      chk("s3_res", 64'({busA.done, busA.timeout, busA.run_cycles}), 64'({2'b11, 16'd1000}));
      chk("s3_runc", 64'(rc), 64'd1000);

      // 4: DEPTH=8 instance, ten-word image overflows
      pulse_start(1'b1, 1'b0);
      stream(1'b1, 10, 1'b0, -1, 32'h2000_0000, acc);
      chk("s4_acc", 64'(acc), 64'd8);
      chk("s4_state", 64'({busB.prog_ready, busB.done, busB.overflow, busB.core_run, busB.busy, busB.timeout}),
          64'b011000);
      chk("s4_norun", 64'(n_runB), 64'd0);
      chk("s4_mem_left", 64'(q_memB.size()), 64'd0);
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      chk("restart_clr_to", 64'(busA.timeout), 64'd1);

      // 5: asynchronous reset during RUN
      pulse_start(1'b0, 1'b1);
      chk("s3_flags_clr", 64'({busA.timeout, busA.run_cycles}), 64'd0);
      stream(1'b0, 4, 1'b0, -1, 32'h3000_0000, acc);
      repeat (5) cyc();
      chk("s5_running", 64'(busA.core_run), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("s5_rst_ctlA", ctl(1'b0), 64'd0);
      chk("s5_rst_ctlB", ctl(1'b1), 64'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // 6: start ignored during LOAD; halt coincides with watchdog
      pc0 = n_pcA;
      pulse_start(1'b0, 1'b1);
      stream(1'b0, 9, 1'b0, 3, 32'h4000_0000, acc);
      chk("s6_acc", 64'(acc), 64'd9);
      chk("s6_regs_left", 64'(q_reg.size()), 64'd0);
      wait_done(TO, 1100, rc);
      chk("s6_res", 64'({busA.done, busA.timeout, busA.run_cycles}), 64'({2'b10, 16'd1000}));
      chk("s6_pcclr", 64'(n_pcA - pc0), 64'd1);
      chk("s6_mem_left", 64'(q_memA.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mips_boot_ctrl.md
Name: mips_boot_ctrl

Overview:
- Sequencer that brings the mips32 core from reset to a completed program run.
- Order of operations: clear all general registers, stream a program image into instruction memory starting at word 0, clear PC and HALTED, then release the core.
- While the core runs, counts cycles until the core raises its halted flag or a watchdog expires.
- Sits between the system/debug host and the core's register-file and memory write ports; it replaces hand-initialisation of Reg, Mem, PC and HALTED.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 1024, number of memory words; must be ≤ 2**ADDR_W.
- NREG, 32, number of general registers cleared.
- CNT_W, 16, cycle counter width.
- TIMEOUT, 1000, run cycles before the watchdog fires; must be < 2**CNT_W.

Ports:
- clk1 input 1: single controller clock (rising edge).
- rst_n input 1: asynchronous, active-low reset.
- start input 1: one-cycle pulse; accepted only in IDLE or DONE.
- prog_valid input 1: program word valid.
- prog_data input 32: program word.
- prog_last input 1: marks the final program word.
- prog_ready output 1: high only in LOAD.
- reg_we output 1: register-file write strobe.
- reg_addr output 5: register index.
- reg_wdata output 32: register write data; always 0.
- mem_we output 1: instruction-memory write strobe.
- mem_addr output ADDR_W: memory word address.
- mem_wdata output 32: memory write data.
- core_pc_clr output 1: clears core PC and HALTED.
- core_run output 1: core enable.
- core_halted input 1: core HALTED flag, synchronous to clk1.
- busy output 1: high in any state except IDLE and DONE.
- done output 1: held high in DONE.
- timeout output 1: watchdog fired on the last run.
- overflow output 1: program longer than DEPTH on the last run.
- run_cycles output CNT_W: cycles spent in RUN on the last run.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; every output 0; internal counters 0. Reset mid-run aborts immediately; memory and register contents are left as written.
- IDLE:
  - start → CLR.
  - On entry from start, clear timeout, overflow and run_cycles.
- CLR:
  - Issue reg_we=1 for NREG consecutive cycles, reg_addr=0..NREG-1, reg_wdata=0.
  - After the last register → LOAD with the word pointer wp=0.
- LOAD:
  - prog_ready=1.
  - A word transfers when prog_valid && prog_ready. On transfer: mem_we=1, mem_addr=wp, mem_wdata=prog_data (registered, one cycle after transfer); then wp++.
  - Transfer with prog_last=1 → PCLR.
  - If a transfer occurs with wp=DEPTH-1 and prog_last=0:
    - write the word, set overflow=1, go to DONE;
    - the core is never released;
    - prog_ready stays low outside LOAD, so excess words are not consumed.
  - An empty image is impossible: at least one word must be accepted.
  - prog_valid low simply stalls; there is no timeout in LOAD.
- PCLR: core_pc_clr=1 for exactly one cycle → RUN.
- RUN:
  - core_run=1; run_cycles increments every cycle, saturating at all-ones.
  - core_halted=1 → DONE; the halting cycle is counted.
  - If run_cycles reaches TIMEOUT first: timeout=1 → DONE.
  - If both occur in the same cycle, halt wins and timeout stays 0.
  - core_halted is ignored outside RUN.
- DONE:
  - core_run=0; done=1; results held.
  - start → CLR (a restart clears the flags and run_cycles on the same cycle).
  - start while busy is ignored.
- reg_we and mem_we are never high together; core_run is never high during CLR, LOAD or PCLR.
- Latency from start to the first reg_we: 1 cycle.

Test Plan:
1. Reset then start; stream 9 words (last word 0xFFFFFFFF with prog_last) with valid always high.
   → 32 reg_we writes of 0; mem writes to addresses 0..8 in order; a single core_pc_clr pulse; core_halted raised at run cycle 12 → done=1, run_cycles=12, timeout=0.
2. Same as scenario 1 but prog_valid toggles every other cycle.
   → Identical memory contents and addresses; LOAD duration doubles; no duplicated or dropped words.
3. core_halted never asserts, with TIMEOUT=1000.
   → DONE after 1000 run cycles; timeout=1; run_cycles=1000.
4. DEPTH=8; stream 10 words with prog_last on word 10.
   → Words 0..7 written; overflow=1; core_run never asserts; words 9 and 10 are left unconsumed with prog_ready=0.
5. Deassert rst_n during RUN.
   → All outputs are 0 immediately (no clock needed); state=IDLE; a new start performs a full CLR/LOAD sequence.
6. Pulse start during LOAD; separately, assert core_halted in the same cycle run_cycles hits TIMEOUT.
   → The start is ignored; in the simultaneous case done=1 and timeout=0.
